// File: rtl/y_sig_checker.sv
// Response compactor: folds each accepted WIDTH-bit sample into a SIG_W-bit MISR
// and compares the result with a golden signature after NUM_SAMPLES samples.
// Optional build macro Y_SIG_CHECKER_SNAPSHOT_EN adds a first_sample capture port.
module y_sig_checker #(
  parameter int               WIDTH       = 119,
  parameter int               SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED        = 32'hFFFFFFFF,
  parameter int               NUM_SAMPLES = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SIG_W-1:0] expected_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      sample_count
`ifdef Y_SIG_CHECKER_SNAPSHOT_EN
  ,
  output logic [WIDTH-1:0] first_sample
`endif
);

  localparam int NCH = (WIDTH + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   reseed;
  logic   accept;

  // Zero-extend to whole chunks and XOR them together; chunk 0 is the LSBs.
  function automatic logic [SIG_W-1:0] fold(input logic [WIDTH-1:0] d);
    logic [NCH*SIG_W-1:0] ext;
    logic [SIG_W-1:0]     f;
    ext              = '0;
    ext[WIDTH-1:0]   = d;
    f                = '0;
    for (int i = 0; i < NCH; i++) begin
      f = f ^ ext[i*SIG_W +: SIG_W];
    end
    return f;
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] f);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}}) ^ f;
  endfunction

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus reseed/accept strobes for the datapath.
  always_comb begin
    state_next = state;
    reseed     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          reseed     = 1'b1;
        end else begin
          state_next = state;
        end
      end
      RUN: begin
        if (start) begin
          reseed = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (sample_count == 16'(NUM_SAMPLES - 1)) begin
            state_next = CHECK;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = RUN;
        end
      end
      CHECK:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Signature, counter, verdict and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      signature    <= SEED;
      sample_count <= 16'd0;
      pass         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      busy <= (state_next == RUN) || (state_next == CHECK);
      done <= (state_next == DONE);
      if (reseed) begin
        signature    <= SEED;
        sample_count <= 16'd0;
        pass         <= 1'b0;
      end else if (accept) begin
        signature    <= misr_next(signature, fold(in_data));
        sample_count <= sample_count + 16'd1;
      end else if (state == CHECK) begin
        pass <= (signature == expected_sig);
      end
    end
  end

`ifdef Y_SIG_CHECKER_SNAPSHOT_EN
  // Capture the first accepted sample of each run.
  always_ff @(posedge clk) begin
    if (rst || reseed) begin
      first_sample <= '0;
    end else if (accept && (sample_count == 16'd0)) begin
      first_sample <= in_data;
    end
  end
`endif

endmodule

// File: tb/tb_y_sig_checker.sv
// Directed self-checking bench for y_sig_checker: one instance with
// NUM_SAMPLES=1 for the hand-computed vectors, one with the default of 21.
module tb_y_sig_checker;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [118:0] in_data;
  logic [31:0]  expected_sig;

  logic         busy1, done1, pass1;
  logic [31:0]  sig1;
  logic [15:0]  cnt1;
  logic         busy, done, pass;
  logic [31:0]  sig;
  logic [15:0]  cnt;
`ifdef Y_SIG_CHECKER_SNAPSHOT_EN
  logic [118:0] first1, first;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model;

  always #5 clk = ~clk;

  y_sig_checker #(.NUM_SAMPLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .expected_sig(expected_sig), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .sample_count(cnt1)
`ifdef Y_SIG_CHECKER_SNAPSHOT_EN
    , .first_sample(first1)
`endif
  );

  y_sig_checker u_dut21 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .expected_sig(expected_sig), .busy(busy), .done(done), .pass(pass),
    .signature(sig), .sample_count(cnt)
`ifdef Y_SIG_CHECKER_SNAPSHOT_EN
    , .first_sample(first)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reference: shift with feedback, then XOR each data bit into bit b mod 32.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [118:0] d);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ POLY;
    for (int b = 0; b < 119; b++) r[b % 32] = r[b % 32] ^ d[b];
    return r;
  endfunction

  function automatic logic [118:0] vec(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {7'(i * 3), 32'hA5A50000 + v, 32'h12345678 ^ (v << 5), 16'hBEEF ^ 16'(i), v};
  endfunction

  task automatic sample(input logic [118:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; expected_sig = '0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_busy", 128'(busy), 128'(1'b0));
    check_eq("rst_done", 128'(done), 128'(1'b0));
    check_eq("rst_pass", 128'(pass), 128'(1'b0));
    check_eq("rst_sig", 128'(sig), 128'(SEED));
    check_eq("rst_cnt", 128'(cnt), 128'(16'd0));

    // Zero sample on the single-sample instance.
    pulse_start();
    check_eq("z_busy", 128'(busy1), 128'(1'b1));
    expected_sig = 32'hFB3EE249;
    sample(119'd0);
    check_eq("z_sig", 128'(sig1), 128'(32'hFB3EE249));
    check_eq("z_cnt", 128'(cnt1), 128'(16'd1));
    check_eq("z_done_early", 128'(done1), 128'(1'b0));
    tick();
    check_eq("z_done", 128'(done1), 128'(1'b1));
    check_eq("z_pass", 128'(pass1), 128'(1'b1));
    check_eq("z_busy_end", 128'(busy1), 128'(1'b0));

    // Fold wrap: bit 96 lands on signature bit 0.
    pulse_start();
    check_eq("w_done_drop", 128'(done1), 128'(1'b0));
    check_eq("w_pass_clr", 128'(pass1), 128'(1'b0));
    expected_sig = 32'h0;
    in_data = '0; in_data[96] = 1'b1;
    sample(in_data);
    check_eq("w_sig", 128'(sig1), 128'(32'hFB3EE248));
    tick();
    check_eq("w_done", 128'(done1), 128'(1'b1));
    check_eq("w_pass", 128'(pass1), 128'(1'b0));

    // Gapped valid, 21 samples.
    rst = 1'b1; tick(); rst = 1'b0;
    model = SEED;
    for (int i = 0; i < 21; i++) model = ref_step(model, vec(i));
    expected_sig = model;
    pulse_start();
    model = SEED;
    for (int i = 0; i < 21; i++) begin
      sample(vec(i));
      model = ref_step(model, vec(i));
      check_eq("g_cnt", 128'(cnt), 128'(i + 1));
      if (i < 20) begin
        check_eq("g_done", 128'(done), 128'(1'b0));
        in_valid = 1'b1; in_data = '1; start = 1'b0;
        in_valid = 1'b0;
        tick();
        check_eq("g_gap_cnt", 128'(cnt), 128'(i + 1));
      end
    end
    check_eq("g_sig", 128'(sig), 128'(model));
    check_eq("g_check_busy", 128'(busy), 128'(1'b1));
    check_eq("g_check_done", 128'(done), 128'(1'b0));
    tick();
    check_eq("g_done_final", 128'(done), 128'(1'b1));
    check_eq("g_pass", 128'(pass), 128'(1'b1));
    in_valid = 1'b1; in_data = vec(99);
    tick(); in_valid = 1'b0;
    check_eq("g_hold_sig", 128'(sig), 128'(model));
    check_eq("g_hold_cnt", 128'(cnt), 128'(16'd21));

    // Abort after 5 samples, then a full run.
    pulse_start();
    for (int i = 0; i < 5; i++) sample(vec(40 + i));
    check_eq("a_cnt5", 128'(cnt), 128'(16'd5));
    start = 1'b1; in_valid = 1'b1; in_data = vec(50);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check_eq("a_sig_seed", 128'(sig), 128'(SEED));
    check_eq("a_cnt0", 128'(cnt), 128'(16'd0));
    for (int i = 0; i < 21; i++) sample(vec(i));
    tick();
    check_eq("a_sig", 128'(sig), 128'(model));
    check_eq("a_done", 128'(done), 128'(1'b1));
    check_eq("a_pass", 128'(pass), 128'(1'b1));

    // Reset mid-run.
    pulse_start();
    for (int i = 0; i < 10; i++) sample(vec(i));
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("r_busy", 128'(busy), 128'(1'b0));
    check_eq("r_done", 128'(done), 128'(1'b0));
    check_eq("r_sig", 128'(sig), 128'(SEED));
    check_eq("r_cnt", 128'(cnt), 128'(16'd0));
    for (int i = 0; i < 3; i++) sample(vec(i));
    check_eq("r_idle_sig", 128'(sig), 128'(SEED));

    // start coincident with rst is ignored.
    rst = 1'b1; start = 1'b1; tick();
    rst = 1'b0; start = 1'b0; tick();
    check_eq("rs_busy", 128'(busy), 128'(1'b0));

`ifdef Y_SIG_CHECKER_SNAPSHOT_EN
    pulse_start();
    check_eq("s_clr1", 128'(first), 128'(119'd0));
    sample(vec(7));
    sample(vec(8));
    check_eq("s_first1", 128'(first), 128'(vec(7)));
    pulse_start();
    check_eq("s_clr2", 128'(first), 128'(119'd0));
    sample(vec(12));
    sample(vec(13));
    check_eq("s_first2", 128'(first), 128'(vec(12)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y_sig_checker.md
# y_sig_checker

Synthesizable response compactor and checker for the fuzz harness. It sits on the far side of the DUT from the stimulus driver. It takes the DUT's wide `y` output once per accepted clock and folds each sample into a 32-bit multiple-input signature register (MISR). After a programmed number of samples it compares the signature against a golden value and reports pass or fail. This replaces per-cycle `$strobe` dumps with a single signature comparison, in simulation and on silicon.

## Interface
Parameters:
- `WIDTH`, 119, width of the observed DUT output bus.
- `SIG_W`, 32, signature width.
- `POLY`, 32'h04C11DB7, MISR feedback polynomial. The implicit x^SIG_W term is not included.
- `SEED`, 32'hFFFFFFFF, signature value at reset and at run start.
- `NUM_SAMPLES`, 21, accepted samples per run. Range 1..65535.

Ports:
- `clk`, in, 1, sole clock. All logic is on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `start`, in, 1, single-cycle pulse that begins a run.
- `in_valid`, in, 1, `in_data` is a sample this cycle.
- `in_data`, in, WIDTH, DUT output `y`.
- `expected_sig`, in, SIG_W, golden signature. Sampled in the CHECK state.
- `busy`, out, 1, high in RUN and CHECK.
- `done`, out, 1, high in DONE.
- `pass`, out, 1, comparison result. Valid only while `done` is high.
- `signature`, out, SIG_W, current MISR value.
- `sample_count`, out, 16, samples accepted in the current run.

## Operation
- **States.** The controller has four states: IDLE, RUN, CHECK, DONE. Encoding is free.
- **Reset.**
  - State goes to IDLE.
  - `busy`, `done`, `pass` go to 0.
  - `signature` goes to SEED.
  - `sample_count` goes to 0.
  - Reset mid-run discards all progress.
- **IDLE.**
  - `start` moves to RUN, loads `signature` with SEED and clears `sample_count`.
  - `in_valid` is ignored.
- **RUN.**
  - Each cycle with `in_valid` high updates the MISR and increments `sample_count`.
  - Accepting sample number NUM_SAMPLES moves to CHECK.
  - `start` in RUN aborts the run and restarts it: reseed, clear count, stay in RUN. Any `in_valid` in that same cycle is dropped.
- **CHECK.**
  - Lasts exactly one cycle.
  - Registers `pass = (signature == expected_sig)` and moves to DONE.
  - `in_valid` is ignored.
- **DONE.**
  - Holds `done`, `pass`, `signature` and `sample_count` stable.
  - `start` behaves as it does in IDLE.
  - `in_valid` is ignored.
- **Fold.**
  - Zero-extend `in_data` to ceil(WIDTH/SIG_W)*SIG_W bits. For WIDTH=119 that is 128 bits.
  - Split into SIG_W-bit chunks; chunk 0 is the LSBs.
  - XOR all chunks to form `f`.
- **MISR update.** `sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ f`.
- **Counter.** `sample_count` never exceeds NUM_SAMPLES, so no wrap is possible.
- **`pass` between runs.** `pass` is cleared whenever a run starts.

## Timing
- **Latency.** A sample accepted on edge N is reflected in `signature` and `sample_count` after edge N.
- **Last sample.** The last sample is accepted at edge N.
  - State is CHECK for the following cycle.
  - `done` and `pass` are valid after edge N+1, i.e. two cycles after the last sample was presented.
- **No backpressure.** Every `in_valid` cycle in RUN is consumed.
- **`start` with `rst`.** `start` coincident with `rst` is ignored.
- **Back-to-back runs.** `start` in DONE drops `done` on the next edge. A new run can begin one cycle after `done` rises.

## Configuration
- **Macro.** `Y_SIG_CHECKER_SNAPSHOT_EN`.
- **When defined:**
  - Adds output `first_sample` (WIDTH bits).
  - It captures `in_data` of the first accepted sample of each run.
  - It resets to 0 and clears at `start`.
- **When undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Zero sample.** NUM_SAMPLES=1, `start`, one `in_valid` with `in_data`=0, `expected_sig`=32'hFB3EE249 → `signature`=32'hFB3EE249; `done`=1 and `pass`=1 two cycles after the sample.
- **Fold wrap.** NUM_SAMPLES=1, one `in_data` with only bit 96 set → `signature`=32'hFB3EE248, proving the top chunk folds onto bit 0. `expected_sig`=0 → `pass`=0.
- **Gapped valid.** NUM_SAMPLES=21, `in_valid` toggled every other cycle, testbench vectors replayed → `sample_count` steps 0..21. The final signature matches the reference model; DONE is reached only after the 21st valid.
- **Abort.** `start` asserted in RUN after 5 samples → `signature`=SEED and `sample_count`=0 on the next edge. A full 21-sample run then gives the same signature as an uninterrupted run.
- **Reset mid-run.** `rst` after 10 samples → IDLE, `busy`=0, `done`=0, `signature`=32'hFFFFFFFF. `in_valid` pulses afterwards do not change `signature`.
- **Snapshot.** Macro defined, two runs with different first samples → `first_sample` equals each run's first accepted `in_data` and is cleared to 0 at each `start`.
